// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, total derivation and scale legality check.
// Shared by vga_scanout and vga_axis_cntr; no ports.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Replication works on the low counter bits, so only powers of two up to 8 are legal.
    function automatic bit scale_ok(input int s);
        return s == 1 || s == 2 || s == 4 || s == 8;
    endfunction

endpackage

// File: rtl/vga_axis_cntr.sv
// vga_axis_cntr: one scan axis counter with active/sync decode.
// Ports: clk_i, rst_i (sync, active high), en_i (advance by one),
//        cnt_o (position), last_o (at TOTAL-1), active_o (cnt < ACTIVE),
//        sync_o (inside the sync window, polarity-free).
module vga_axis_cntr #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o   = cnt_q == W'(TOTAL - 1);
    assign active_o = cnt_q < W'(ACTIVE);
    assign sync_o   = cnt_q >= W'(ACTIVE + FP) && cnt_q < W'(ACTIVE + FP + SYNC);
    assign cnt_o    = cnt_q;
    assign cnt_d    = !en_i ? cnt_q : last_o ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk_i) begin
        cnt_q <= rst_i ? '0 : cnt_d;
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out with pixel replication and double-buffered base.
// Ports: clk_i, rst_i (sync, active high), fb_base_i (base for next frame),
//        pixel_data_i (fb data, one clock after pixel_addr_o), irq_ack_i,
//        test_en_i (only with VGA_SCANOUT_TESTPAT_EN), pixel_addr_o, pixel_o,
//        h_sync_o, v_sync_o, frame_start_o, vblank_irq_o.
// Define VGA_SCANOUT_TESTPAT_EN to add the test_en_i XOR test pattern.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SCALE    = 2,
    parameter int PIXEL_W  = 12,
    parameter int ADDR_W   = 17,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  fb_base_i,
    input  logic [PIXEL_W-1:0] pixel_data_i,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic               test_en_i,
`endif
    input  logic               irq_ack_i,
    output logic [ADDR_W-1:0]  pixel_addr_o,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               h_sync_o,
    output logic               v_sync_o,
    output logic               frame_start_o,
    output logic               vblank_irq_o
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FB_W    = H_ACTIVE / SCALE;

    if (!scale_ok(SCALE)) begin : g_bad_scale
        $error("vga_scanout: SCALE must be 1, 2, 4 or 8");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic h_last, h_act, h_syn, v_last, v_act, v_syn;

    vga_axis_cntr #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_h (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1),
        .cnt_o(hcnt), .last_o(h_last), .active_o(h_act), .sync_o(h_syn)
    );

    vga_axis_cntr #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_v (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(h_last),
        .cnt_o(vcnt), .last_o(v_last), .active_o(v_act), .sync_o(v_syn)
    );

    logic [ADDR_W-1:0]  cur_base_q, cur_base_d, row_q, row_d, col_q, col_d;
    logic               irq_q, irq_d;
    logic               act1_q, fs1_q, hs1_q, vs1_q;
    logic               hs_q, vs_q, fs_q;
    logic [PIXEL_W-1:0] pixel_q, pixel_d, pix_src;
    logic               frame_end, line_end, col_step, row_step, irq_set, act;

    always_comb begin
        act        = h_act & v_act;
        frame_end  = h_last & v_last;
        line_end   = v_act & (hcnt == HW'(H_ACTIVE - 1));
        // Low counter bits act as the replication sub-counters.
        col_step   = (hcnt & HW'(SCALE - 1)) == HW'(SCALE - 1);
        row_step   = (vcnt & VW'(SCALE - 1)) == VW'(SCALE - 1);
        irq_set    = h_last & (vcnt == VW'(V_ACTIVE - 1));
        col_d      = h_last ? '0 : (h_act & col_step) ? col_q + ADDR_W'(1) : col_q;
        row_d      = frame_end ? fb_base_i : (line_end & row_step) ? row_q + ADDR_W'(FB_W) : row_q;
        cur_base_d = frame_end ? fb_base_i : cur_base_q;
        irq_d      = irq_set | (irq_q & ~irq_ack_i);
        pixel_d    = act1_q ? pix_src : '0;
    end

    assign pixel_addr_o  = act ? row_q + col_q : cur_base_q;
    assign pixel_o       = pixel_q;
    assign h_sync_o      = hs_q;
    assign v_sync_o      = vs_q;
    assign frame_start_o = fs_q;
    assign vblank_irq_o  = irq_q;

`ifdef VGA_SCANOUT_TESTPAT_EN
    logic [4:0]         pat5;
    logic [PIXEL_W-1:0] pat_d, pat_q;

    always_comb begin
        pat5 = 5'(hcnt) ^ 5'(vcnt);
        for (int i = 0; i < PIXEL_W; i++) pat_d[i] = pat5[i % 5];
    end

    always_ff @(posedge clk_i) begin
        pat_q <= rst_i ? '0 : pat_d;
    end

    assign pix_src = test_en_i ? pat_q : pixel_data_i;
`else
    assign pix_src = pixel_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_base_q <= fb_base_i;
            row_q      <= fb_base_i;
            col_q      <= '0;
            irq_q      <= 1'b0;
            act1_q     <= 1'b0;
            fs1_q      <= 1'b0;
            hs1_q      <= ~SYNC_POL;
            vs1_q      <= ~SYNC_POL;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            fs_q       <= 1'b0;
            pixel_q    <= '0;
        end else begin
            cur_base_q <= cur_base_d;
            row_q      <= row_d;
            col_q      <= col_d;
            irq_q      <= irq_d;
            act1_q     <= act;
            fs1_q      <= (hcnt == '0) & (vcnt == '0);
            hs1_q      <= h_syn ? SYNC_POL : ~SYNC_POL;
            vs1_q      <= v_syn ? SYNC_POL : ~SYNC_POL;
            hs_q       <= hs1_q;
            vs_q       <= vs1_q;
            fs_q       <= fs1_q;
            pixel_q    <= pixel_d;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of a tiny 8x4 (14x7 total) SCALE 2 scan-out.
module tb_vga_scanout;

    logic        clk_i = 1'b0;
    logic        rst_i, irq_ack_i;
    logic [16:0] fb_base_i, pixel_addr_o;
    logic [11:0] pixel_data_i = '0;
    logic [11:0] pixel_o;
    logic        h_sync_o, v_sync_o, frame_start_o, vblank_irq_o;
`ifdef VGA_SCANOUT_TESTPAT_EN
    logic        test_en_i = 1'b0;
`endif

    int errors = 0, checks = 0, cyc = 0, hlow = 0, vlow = 0;
    logic [16:0] line_tbl [8] = '{17'h100, 17'h100, 17'h101, 17'h101,
                                  17'h102, 17'h102, 17'h103, 17'h103};

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE(2), .PIXEL_W(12), .ADDR_W(17), .SYNC_POL(1'b0)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .fb_base_i(fb_base_i), .pixel_data_i(pixel_data_i),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .test_en_i(test_en_i),
`endif
        .irq_ack_i(irq_ack_i), .pixel_addr_o(pixel_addr_o), .pixel_o(pixel_o),
        .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .frame_start_o(frame_start_o),
        .vblank_irq_o(vblank_irq_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] fb(input logic [16:0] a);
        return a[11:0] ^ 12'hA5A;
    endfunction

    always @(posedge clk_i) pixel_data_i <= fb(pixel_addr_o);

    task automatic tick();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        irq_ack_i = 1'b0;
        fb_base_i = 17'h100;
        repeat (3) @(negedge clk_i);
        chk("rst_pixel", 32'(pixel_o), 32'h0);
        chk("rst_addr", 32'(pixel_addr_o), 32'h100);
        chk("rst_hsync", 32'(h_sync_o), 32'h1);
        chk("rst_vsync", 32'(v_sync_o), 32'h1);
        chk("rst_fstart", 32'(frame_start_o), 32'h0);
        chk("rst_irq", 32'(vblank_irq_o), 32'h0);
        rst_i = 1'b0;
        cyc = 0;
        for (int c = 0; c < 98; c++) begin
            goto(c);
            if (c < 22 && c % 14 < 8) chk("addr_line01", 32'(pixel_addr_o), 32'(line_tbl[c % 14]));
            if (c >= 14 && c < 28 && !h_sync_o) hlow++;
            if (!v_sync_o) vlow++;
            case (c)
                1:  chk("fstart_early", 32'(frame_start_o), 32'h0);
                2:  begin
                        chk("fstart", 32'(frame_start_o), 32'h1);
                        chk("pixel_first", 32'(pixel_o), 32'(fb(17'h100)));
                    end
                8:  chk("addr_blank", 32'(pixel_addr_o), 32'h100);
                9:  chk("pixel_last", 32'(pixel_o), 32'(fb(17'h103)));
                10: chk("pixel_blank", 32'(pixel_o), 32'h0);
                11: chk("hsync_pre", 32'(h_sync_o), 32'h1);
                12: chk("hsync_on", 32'(h_sync_o), 32'h0);
                14: chk("hsync_off", 32'(h_sync_o), 32'h1);
                28: chk("addr_line2", 32'(pixel_addr_o), 32'h104);
                30: fb_base_i = 17'h200;
                42: chk("addr_line3_oldbase", 32'(pixel_addr_o), 32'h104);
                55: begin
                        chk("irq_pre", 32'(vblank_irq_o), 32'h0);
                        irq_ack_i = 1'b1;
                    end
                56: chk("irq_set_wins", 32'(vblank_irq_o), 32'h1);
                57: begin
                        chk("irq_acked", 32'(vblank_irq_o), 32'h0);
                        irq_ack_i = 1'b0;
                    end
                71: chk("vsync_pre", 32'(v_sync_o), 32'h1);
                72: chk("vsync_on", 32'(v_sync_o), 32'h0);
                default: ;
            endcase
        end
        chk("hsync_low_per_line", 32'(hlow), 32'd2);
        chk("vsync_low_per_frame", 32'(vlow), 32'd14);
        goto(98);
        chk("addr_newbase", 32'(pixel_addr_o), 32'h200);
        goto(100);
        chk("fstart_frame2", 32'(frame_start_o), 32'h1);
        chk("pixel_frame2", 32'(pixel_o), 32'(fb(17'h200)));
        goto(103);
        chk("pixel_before_rst", 32'(pixel_o), 32'(fb(17'h201)));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cyc = 0;
        chk("midrst_addr", 32'(pixel_addr_o), 32'h200);
        chk("midrst_pixel0", 32'(pixel_o), 32'h0);
        tick();
        chk("midrst_pixel1", 32'(pixel_o), 32'h0);
        tick();
        chk("midrst_pixel2", 32'(pixel_o), 32'(fb(17'h200)));
        chk("midrst_fstart", 32'(frame_start_o), 32'h1);
        goto(12);
        chk("hsync_before_rst", 32'(h_sync_o), 32'h0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cyc = 0;
        chk("syncrst_hsync", 32'(h_sync_o), 32'h1);
        chk("syncrst_vsync", 32'(v_sync_o), 32'h1);
        chk("syncrst_pixel", 32'(pixel_o), 32'h0);
        goto(28);
        chk("addr_line2_newbase", 32'(pixel_addr_o), 32'h204);
        goto(56);
        chk("irq_frame", 32'(vblank_irq_o), 32'h1);
`ifdef VGA_SCANOUT_TESTPAT_EN
        test_en_i = 1'b1;
        goto(117);
        chk("testpat_3_1", 32'(pixel_o), 32'h842);
        test_en_i = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
